// File: rtl/mem_step_ctrl_if.sv
// Memory bus between the step controller and a synchronous single-port RAM.
// The controller drives address/write; the RAM returns registered read data.
interface mem_step_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_step_ctrl.sv
// Steps a read address over a synchronous RAM on tick/step edges,
// writes switch data on request and holds the last word read back.
module mem_step_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              tick,
    input  logic              run,
    input  logic              step,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    mem_step_ctrl_if.master   mem,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_LAT + 1) + 1;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              tick_q, tick_d;
    logic              step_q, step_d;
    logic              wr_q, wr_d;
    logic              pend_adv_q, pend_adv_d;
    logic              pend_wr_q, pend_wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic adv_ev;
    logic wr_ev;

    assign adv_ev = (tick & ~tick_q & run) | (step & ~step_q);
    assign wr_ev  = wr_req & ~wr_q;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick;
        step_d     = step;
        wr_d       = wr_req;
        pend_adv_d = pend_adv_q | adv_ev;
        pend_wr_d  = pend_wr_q | wr_ev;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_ev | pend_wr_q) begin
                    we_d      = 1'b1;
                    wdata_d   = wr_data;
                    rvalid_d  = 1'b0;
                    pend_wr_d = 1'b0;
                    state_d   = S_WRITE;
                end else if (adv_ev | pend_adv_q) begin
                    addr_d     = addr_q + 1'b1;
                    rvalid_d   = 1'b0;
                    pend_adv_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_READ;
                end
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                // RAM output is registered; capture it one clock after it settles
                if (cnt_q == LAT) begin
                    rdata_d  = mem.mem_rdata;
                    rvalid_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_READ;
            tick_q     <= 1'b1;
            step_q     <= 1'b1;
            wr_q       <= 1'b1;
            pend_adv_q <= 1'b0;
            pend_wr_q  <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
            wr_q       <= wr_d;
            pend_adv_q <= pend_adv_d;
            pend_wr_q  <= pend_wr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;
    assign rd_data       = rdata_q;
    assign rd_valid      = rvalid_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_step_ctrl.sv
// Directed bench for mem_step_ctrl: per-clock vector table plus
// hand-written busy/reset-abort sequences against a preloaded RAM model.
module tb_mem_step_ctrl;
    logic        clk = 1'b0;
    logic        rst, tick, run, step, wr_req;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid, busy;
    logic [31:0] mem [64];

    int n_vec = 0;
    int n_bad = 0;

    mem_step_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    mem_step_ctrl #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk_in   (clk),
        .rst      (rst),
        .tick     (tick),
        .run      (run),
        .step     (step),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .mem      (bus),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i * 3;
    end

    // one-clock read latency, read-after-write
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];
    end

    typedef struct {
        logic        rst, run, tick, step, wr;
        logic [31:0] wd;
        logic [5:0]  a;
        logic        we, v;
        logic [31:0] d;
        logic        b;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic r, logic rn, logic tk, logic st, logic w,
                                logic [31:0] wd, logic [5:0] a, logic we,
                                logic v, logic [31:0] d, logic b);
        vec_t x;
        x.rst = r; x.run = rn; x.tick = tk; x.step = st; x.wr = w; x.wd = wd;
        x.a = a; x.we = we; x.v = v; x.d = d; x.b = b;
        vq.push_back(x);
    endfunction

    function automatic void add_idle(logic rn, int n, logic [5:0] a, logic [31:0] d);
        for (int i = 0; i < n; i++) add(0, rn, 0, 0, 0, 0, a, 0, 1, d, 0);
    endfunction

    function automatic void add_adv(logic rn, logic tk, logic st, logic [5:0] a,
                                    logic [31:0] d_old, logic [31:0] d_new);
        add(0, rn, tk, st, 0, 0, a, 0, 0, d_old, 1);
        add(0, rn, 0, 0, 0, 0, a, 0, 0, d_old, 1);
        add(0, rn, 0, 0, 0, 0, a, 0, 1, d_new, 0);
    endfunction

    task automatic cyc(logic r, logic rn, logic tk, logic st, logic w, logic [31:0] wd);
        @(negedge clk);
        rst = r; run = rn; tick = tk; step = st; wr_req = w; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        bit got_valid;
        rst = 1; run = 0; tick = 0; step = 0; wr_req = 0; wr_data = 0;

        // reset and automatic fetch of word 0
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add_idle(0, 2, 0, 0);
        // auto-run on tick
        for (int i = 1; i <= 3; i++) begin
            add_adv(1, 1, 0, 6'(i), 32'((i - 1) * 3), 32'(i * 3));
            add_idle(1, 7, 6'(i), 32'(i * 3));
        end
        // paused: tick ignored, run rise with tick high ignored
        for (int i = 0; i < 2; i++) begin
            add(0, 0, 1, 0, 0, 0, 3, 0, 1, 9, 0);
            add_idle(0, 2, 3, 9);
        end
        add(0, 0, 1, 0, 0, 0, 3, 0, 1, 9, 0);
        add(0, 1, 1, 0, 0, 0, 3, 0, 1, 9, 0);
        add(0, 1, 1, 0, 0, 0, 3, 0, 1, 9, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0, 1, 9, 0);
        add_adv(0, 0, 1, 4, 9, 12);
        add_idle(0, 2, 4, 12);
        add_adv(1, 1, 1, 5, 12, 15);
        add_idle(1, 3, 5, 15);
        // write then read-back
        add(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 5, 1, 0, 15, 1);
        add(0, 0, 0, 0, 0, 0, 5, 0, 0, 15, 1);
        add(0, 0, 0, 0, 0, 0, 5, 0, 0, 15, 1);
        add(0, 0, 0, 0, 0, 0, 5, 0, 1, 32'hDEAD_BEEF, 0);
        add_idle(0, 2, 5, 32'hDEAD_BEEF);
        // write + step together: advance deferred until read-back done
        add(0, 0, 0, 1, 1, 32'hCAFE_F00D, 5, 1, 0, 32'hDEAD_BEEF, 1);
        add(0, 0, 0, 0, 0, 0, 5, 0, 0, 32'hDEAD_BEEF, 1);
        add(0, 0, 0, 0, 0, 0, 5, 0, 0, 32'hDEAD_BEEF, 1);
        add(0, 0, 0, 0, 0, 0, 5, 0, 1, 32'hCAFE_F00D, 0);
        add(0, 0, 0, 0, 0, 0, 6, 0, 0, 32'hCAFE_F00D, 1);
        add(0, 0, 0, 0, 0, 0, 6, 0, 0, 32'hCAFE_F00D, 1);
        add(0, 0, 0, 0, 0, 0, 6, 0, 1, 18, 0);
        add_idle(0, 2, 6, 18);
        // step up to 63 then wrap
        for (int i = 7; i <= 63; i++) add_adv(0, 0, 1, 6'(i), 32'((i - 1) * 3), 32'(i * 3));
        add_adv(0, 0, 1, 0, 189, 0);
        add_idle(0, 2, 0, 0);

        foreach (vq[i]) begin
            logic [40:0] act, exp;
            cyc(vq[i].rst, vq[i].run, vq[i].tick, vq[i].step, vq[i].wr, vq[i].wd);
            act = {bus.mem_addr, bus.mem_we, rd_valid, rd_data, busy};
            exp = {vq[i].a, vq[i].we, vq[i].v, vq[i].d, vq[i].b};
            n_vec++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL vec%0d: addr/we/valid/data/busy got %0d/%b/%b/%h/%b expected %0d/%b/%b/%h/%b",
                         i, bus.mem_addr, bus.mem_we, rd_valid, rd_data, busy,
                         vq[i].a, vq[i].we, vq[i].v, vq[i].d, vq[i].b);
            end
        end

        // step during read: exactly one deferred advance
        cyc(0, 0, 0, 1, 0, 0);
        check("busy_step_addr", 32'(bus.mem_addr), 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("busy_step_busy", 32'(busy), 1);
        cyc(0, 0, 0, 1, 0, 0);
        check("busy_step_cap", rd_data, 3);
        cyc(0, 0, 0, 0, 0, 0);
        check("pend_adv_addr", 32'(bus.mem_addr), 2);
        check("pend_adv_valid", 32'(rd_valid), 0);
        got_valid = 0;
        for (int i = 0; i < 8 && !got_valid; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            got_valid = rd_valid;
        end
        check("pend_adv_done", 32'(got_valid), 1);
        check("pend_adv_data", rd_data, 6);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        check("pend_adv_once", 32'(bus.mem_addr), 2);

        // reset during write with advance pending; step held high through reset
        cyc(0, 0, 0, 1, 1, 32'h1234_5678);
        check("rstw_we", 32'(bus.mem_we), 1);
        cyc(1, 0, 0, 1, 0, 0);
        check("rstw_we_off", 32'(bus.mem_we), 0);
        check("rstw_addr", 32'(bus.mem_addr), 0);
        check("rstw_valid", 32'(rd_valid), 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("rstw_fetch_valid", 32'(rd_valid), 1);
        check("rstw_fetch_data", rd_data, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        check("rstw_no_pend_addr", 32'(bus.mem_addr), 0);
        check("rstw_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
